// File: rtl/branch_resolver.sv
// branch_resolver: resolves BRANCH/JAL/JALR for the fetch/PC stage.
// Captures a control-flow op in IDLE, presents a registered decision
// (b_taken/up_amt) during RESOLVE and pulses FLUSH during REDIRECT.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_resolver #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [31:0]             INSTR,
  input  logic [WIDTH-1:0]        IP,
  input  logic [WIDTH-1:0]        RS1_DATA,
  input  logic [WIDTH-1:0]        RS2_DATA,
  output logic                    b_taken,
  output logic signed [WIDTH-1:0] up_amt,
  output logic                    FLUSH,
  output logic                    BUSY
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]        br_count,
  output logic [CNT_W-1:0]        tk_count
`endif
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RESOLVE  = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t           state_q;
  logic             b_taken_q;
  logic             flush_q;
  logic [WIDTH-1:0] up_amt_q;

  logic             is_cf;
  logic             taken_d;
  logic [WIDTH-1:0] amt_d;
  logic [WIDTH-1:0] b_imm;
  logic [WIDTH-1:0] j_imm;
  logic [WIDTH-1:0] i_imm;
  logic [WIDTH-1:0] jalr_sum;
  logic [WIDTH-1:0] jalr_tgt;
  logic             rs_eq;
  logic             rs_lt_s;
  logic             rs_lt_u;

  // Immediates: INSTR[31] is the sign bit of every format.
  assign b_imm = {{(WIDTH-12){INSTR[31]}}, INSTR[7], INSTR[30:25], INSTR[11:8], 1'b0};
  assign j_imm = {{(WIDTH-20){INSTR[31]}}, INSTR[19:12], INSTR[20], INSTR[30:21], 1'b0};
  assign i_imm = {{(WIDTH-11){INSTR[31]}}, INSTR[30:20]};

  // JALR target has bit 0 cleared; the offset is relative to the current IP.
  assign jalr_sum = RS1_DATA + i_imm;
  assign jalr_tgt = jalr_sum & ~{{(WIDTH-1){1'b0}}, 1'b1};

  assign rs_eq   = (RS1_DATA == RS2_DATA);
  assign rs_lt_s = ($signed(RS1_DATA) < $signed(RS2_DATA));
  assign rs_lt_u = (RS1_DATA < RS2_DATA);

  assign is_cf = (INSTR[6:0] == OP_BRANCH) || (INSTR[6:0] == OP_JAL) ||
                 (INSTR[6:0] == OP_JALR);

  // Decision for the op currently on INSTR; only sampled while IDLE.
  always_comb begin
    taken_d = 1'b0;
    amt_d   = {WIDTH{1'b0}};
    case (INSTR[6:0])
      OP_BRANCH: begin
        amt_d = b_imm;
        case (INSTR[14:12])
          3'b000:  taken_d = rs_eq;
          3'b001:  taken_d = !rs_eq;
          3'b100:  taken_d = rs_lt_s;
          3'b101:  taken_d = !rs_lt_s;
          3'b110:  taken_d = rs_lt_u;
          3'b111:  taken_d = !rs_lt_u;
          default: begin
            // funct3 010/011 are not branches: never taken, no offset.
            taken_d = 1'b0;
            amt_d   = {WIDTH{1'b0}};
          end
        endcase
      end
      OP_JAL: begin
        taken_d = 1'b1;
        amt_d   = j_imm;
      end
      OP_JALR: begin
        taken_d = 1'b1;
        amt_d   = jalr_tgt - IP;
      end
      default: begin
        taken_d = 1'b0;
        amt_d   = {WIDTH{1'b0}};
      end
    endcase
  end

  // Control FSM with registered decision and flush outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      b_taken_q <= 1'b0;
      up_amt_q  <= {WIDTH{1'b0}};
      flush_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          flush_q <= 1'b0;
          if (is_cf) begin
            state_q   <= S_RESOLVE;
            b_taken_q <= taken_d;
            up_amt_q  <= amt_d;
          end else begin
            state_q   <= S_IDLE;
            b_taken_q <= 1'b0;
            up_amt_q  <= {WIDTH{1'b0}};
          end
        end
        S_RESOLVE: begin
          // Inputs are ignored here: the stalled opcode must not re-trigger.
          if (b_taken_q) begin
            state_q   <= S_REDIRECT;
            flush_q   <= 1'b1;
            b_taken_q <= 1'b0;
          end else begin
            state_q   <= S_IDLE;
            flush_q   <= 1'b0;
            b_taken_q <= 1'b0;
            up_amt_q  <= {WIDTH{1'b0}};
          end
        end
        S_REDIRECT: begin
          state_q   <= S_IDLE;
          flush_q   <= 1'b0;
          b_taken_q <= 1'b0;
          up_amt_q  <= {WIDTH{1'b0}};
        end
        default: begin
          state_q   <= S_IDLE;
          flush_q   <= 1'b0;
          b_taken_q <= 1'b0;
          up_amt_q  <= {WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign b_taken = b_taken_q;
  assign up_amt  = up_amt_q;
  assign FLUSH   = flush_q;
  assign BUSY    = (state_q != S_IDLE);

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] br_count_q;
  logic [CNT_W-1:0] tk_count_q;

  // Saturating counters: resolved ops and taken redirects.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      br_count_q <= {CNT_W{1'b0}};
      tk_count_q <= {CNT_W{1'b0}};
    end else begin
      if ((state_q == S_RESOLVE) && (br_count_q != {CNT_W{1'b1}})) begin
        br_count_q <= br_count_q + CNT_W'(1);
      end else begin
        br_count_q <= br_count_q;
      end
      if ((state_q == S_RESOLVE) && b_taken_q && (tk_count_q != {CNT_W{1'b1}})) begin
        tk_count_q <= tk_count_q + CNT_W'(1);
      end else begin
        tk_count_q <= tk_count_q;
      end
    end
  end

  assign br_count = br_count_q;
  assign tk_count = tk_count_q;
`else
  // Keeps the counter width parameter referenced when statistics are absent.
  logic [CNT_W-1:0] unused_cnt_s;
  assign unused_cnt_s = {CNT_W{1'b0}};
`endif

endmodule
